// File: rtl/find_mode_param.sv
// ============================================================================
// Module   : find_mode_param
// Brief    : Streaming mode finder over a bounded distinct-value table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module find_mode_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next,
    input  logic [DATA_W-1:0] number,
    input  logic              clear,
    output logic [DATA_W-1:0] out,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [CNT_W-1:0]  total,
    output logic              valid,
    output logic              overflow
);

    localparam int              C_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic              used_q [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic              used_d [DEPTH];
    logic [DATA_W-1:0] val_d  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];

    logic [DATA_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;

    logic [DEPTH-1:0]   hit_vec;
    logic               hit;
    logic               full;
    logic [C_IDX_W-1:0] hit_idx;
    logic [C_IDX_W-1:0] free_idx;
    logic [C_IDX_W-1:0] touch_idx;
    logic [CNT_W-1:0]   cnt_cur;
    logic [CNT_W-1:0]   c_new;
    logic               touched;
    logic               dropped;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            assign hit_vec[g] = used_q[g] && (val_q[g] == number);
        end
    endgenerate

    // A value is stored at most once, so the hit vector is one-hot or zero.
    always_comb begin
        hit      = |hit_vec;
        hit_idx  = '0;
        free_idx = '0;
        full     = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) hit_idx = C_IDX_W'(i);
            if (!used_q[i]) full = 1'b0;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!used_q[i]) free_idx = C_IDX_W'(i);
        end
    end

    always_comb begin
        touch_idx = hit ? hit_idx : free_idx;
        cnt_cur   = hit ? cnt_q[hit_idx] : '0;
        c_new     = (cnt_cur == C_CNT_MAX) ? cnt_cur : cnt_cur + 1'b1;
        touched   = next && (hit || !full);
        dropped   = next && !hit && full;
    end

    always_comb begin
        used_d     = used_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_cnt_d  = out_cnt_q;
        total_d    = total_q;
        valid_d    = valid_q | next;
        overflow_d = overflow_q | dropped;
        if (next && (total_q != C_CNT_MAX)) begin
            total_d = total_q + 1'b1;
        end
        if (touched) begin
            used_d[touch_idx] = 1'b1;
            val_d[touch_idx]  = number;
            cnt_d[touch_idx]  = c_new;
            // Strictly greater wins; the incumbent keeps tracking its own count.
            if ((c_new > out_cnt_q) || (valid_q && (number == out_q))) begin
                out_d     = number;
                out_cnt_d = c_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                used_q[i] <= 1'b0;
                val_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
            out_q      <= '0;
            out_cnt_q  <= '0;
            total_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            used_q     <= used_d;
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            out_cnt_q  <= out_cnt_d;
            total_q    <= total_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign out_cnt  = out_cnt_q;
    assign total    = total_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_find_mode_param.sv
// ============================================================================
// Module   : tb_find_mode_param
// Brief    : Scoreboard bench for find_mode_param, default and small configs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_find_mode_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       next = 1'b0;
    logic [7:0] number = '0;

    logic [7:0] out0, cnt0, tot0;
    logic       vld0, ovf0;
    logic [7:0] out1;
    logic [2:0] cnt1, tot1;
    logic       vld1, ovf1;

    always #5 clk = ~clk;

    find_mode_param #(.DATA_W(8), .DEPTH(16), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .next(next), .number(number), .clear(clear),
        .out(out0), .out_cnt(cnt0), .total(tot0), .valid(vld0), .overflow(ovf0)
    );

    find_mode_param #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .next(next), .number(number), .clear(clear),
        .out(out1), .out_cnt(cnt1), .total(tot1), .valid(vld1), .overflow(ovf1)
    );

    typedef struct packed {
        logic [7:0] out;
        logic [7:0] cnt;
        logic [7:0] tot;
        logic       vld;
        logic       ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: per-value occurrence counts plus a distinct-value tally.
    int mcnt [2][256];
    int mdist[2];
    int mout [2];
    int mocnt[2];
    int mtot [2];
    bit mval [2];
    bit movf [2];
    int dep  [2] = '{16, 4};
    int cmax [2] = '{255, 7};

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input int i, input bit r, input bit c, input bit n, input int v);
        int  cn;
        bit  tch;
        if (r || c) begin
            for (int k = 0; k < 256; k++) mcnt[i][k] = 0;
            mdist[i] = 0; mout[i] = 0; mocnt[i] = 0; mtot[i] = 0;
            mval[i] = 0; movf[i] = 0;
        end else if (n) begin
            tch = 1;
            cn  = 0;
            if (mtot[i] < cmax[i]) mtot[i]++;
            if (mcnt[i][v] > 0) begin
                if (mcnt[i][v] < cmax[i]) mcnt[i][v]++;
                cn = mcnt[i][v];
            end else if (mdist[i] < dep[i]) begin
                mcnt[i][v] = 1;
                mdist[i]++;
                cn = 1;
            end else begin
                movf[i] = 1;
                tch = 0;
            end
            if (tch && (cn > mocnt[i] || (mval[i] && v == mout[i]))) begin
                mout[i]  = v;
                mocnt[i] = cn;
            end
            mval[i] = 1;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit n, input int v);
        exp_t e;
        @(negedge clk);
        rst = r; clear = c; next = n; number = 8'(v);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model(i, r, c, n, v);
        e.out = 8'(mout[0]); e.cnt = 8'(mocnt[0]); e.tot = 8'(mtot[0]);
        e.vld = mval[0]; e.ovf = movf[0];
        q0.push_back(e);
        e.out = 8'(mout[1]); e.cnt = 8'(mocnt[1]); e.tot = 8'(mtot[1]);
        e.vld = mval[1]; e.ovf = movf[1];
        q1.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("sb0_out", int'(out0), int'(e.out));
            chk("sb0_cnt", int'(cnt0), int'(e.cnt));
            chk("sb0_total", int'(tot0), int'(e.tot));
            chk("sb0_valid", int'(vld0), int'(e.vld));
            chk("sb0_overflow", int'(ovf0), int'(e.ovf));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("sb1_out", int'(out1), int'(e.out));
            chk("sb1_cnt", int'(cnt1), int'(e.cnt));
            chk("sb1_total", int'(tot1), int'(e.tot));
            chk("sb1_valid", int'(vld1), int'(e.vld));
            chk("sb1_overflow", int'(ovf1), int'(e.ovf));
        end
    end

    int base_seq[19] = '{10, 20, 30, 10, 10, 20, 30, 30, 30, 30, 30, 30,
                         10, 10, 10, 10, 10, 10, 10};

    initial begin
        int v;
        bit r, c, n;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_out", int'(out0), 0);
        chk("reset_cnt", int'(cnt0), 0);
        chk("reset_total", int'(tot0), 0);
        chk("reset_valid", int'(vld0), 0);
        chk("reset_ovf", int'(ovf0), 0);

        // Baseline on the default configuration
        for (int k = 0; k < 19; k++) begin
            step(0, 0, 1, base_seq[k]);
            if (k == 4)  begin chk("base5_out", int'(out0), 10); chk("base5_cnt", int'(cnt0), 3); end
            if (k == 8)  begin chk("base30x4_out", int'(out0), 30); chk("base30x4_cnt", int'(cnt0), 4); end
            if (k == 11) begin chk("base30end_out", int'(out0), 30); chk("base30end_cnt", int'(cnt0), 7); end
            if (k == 16) chk("base10x8_out", int'(out0), 10);
        end
        step(0, 0, 0, 0);
        chk("base_fin_out", int'(out0), 10);
        chk("base_fin_cnt", int'(cnt0), 10);
        chk("base_fin_total", int'(tot0), 19);
        chk("base_fin_valid", int'(vld0), 1);
        chk("base_fin_ovf", int'(ovf0), 0);

        // Tie rule
        step(1, 0, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 1, 6);
        chk("tie1_out", int'(out0), 5); chk("tie1_cnt", int'(cnt0), 1);
        step(0, 0, 1, 6);
        chk("tie2_out", int'(out0), 6); chk("tie2_cnt", int'(cnt0), 2);
        step(0, 0, 1, 5);
        chk("tie3_out", int'(out0), 6); chk("tie3_cnt", int'(cnt0), 2);

        // Overflow on the DEPTH=4 instance
        step(1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, 0, 1, k);
        chk("ovf_flag", int'(ovf1), 1);
        chk("ovf_flag_big", int'(ovf0), 0);
        step(0, 0, 1, 5);
        chk("ovf_total", int'(tot1), 6);
        chk("ovf_out", int'(out1), 1); chk("ovf_cnt", int'(cnt1), 1);
        step(0, 0, 1, 2);
        chk("ovf2_out", int'(out1), 2); chk("ovf2_cnt", int'(cnt1), 2);
        chk("ovf2_valid", int'(vld1), 1);

        // Saturation on the CNT_W=3 instance
        step(1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 1, 7);
            if (k == 7 || k == 10) begin
                chk("sat_cnt", int'(cnt1), 7); chk("sat_total", int'(tot1), 7);
            end
        end
        for (int k = 0; k < 3; k++) step(0, 0, 1, 9);
        chk("sat_keep_out", int'(out1), 7);

        // Clear, then reset, in the middle of a stream
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 0, 0, 0);
            step(0, 0, 1, 10);
            step(0, 0, 1, 10);
            step(0, 0, 1, 20);
            step(pass == 1, pass == 0, 1, 20);
            chk("clr_out", int'(out0), 0); chk("clr_cnt", int'(cnt0), 0);
            chk("clr_total", int'(tot0), 0); chk("clr_valid", int'(vld0), 0);
            step(0, 0, 1, 20);
            chk("clr_next_out", int'(out0), 20); chk("clr_next_cnt", int'(cnt0), 1);
            chk("clr_next_total", int'(tot0), 1);
        end

        // Idle hold while number toggles
        for (int k = 0; k < 5; k++) step(0, 0, 0, (k % 2) ? 8'hFF : 8'h00);
        chk("idle_out", int'(out0), 20);
        chk("idle_total", int'(tot0), 1);

        // Saturation of the default-width counters
        step(1, 0, 0, 0);
        for (int k = 0; k < 260; k++) step(0, 0, 1, 42);
        chk("sat8_cnt", int'(cnt0), 255);
        chk("sat8_total", int'(tot0), 255);

        // Randomized traffic
        step(1, 0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 149) == 0);
            n = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 6));
            step(r, c, n, v);
        end

        @(negedge clk);
        #1;
        chk("sb_drain", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
